// File: rtl/pool_pkg.sv
// Shared definitions for the hash-core pool sequencer: state encoding and
// default timing constants.
package pool_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_FOUND,
        ST_EXHAUSTED
    } pool_state_e;

    localparam int DEF_LOCK_CYCLES  = 1024;
    localparam int DEF_LED_DIV_LOG2 = 22;

endpackage

// File: rtl/pool_priority_encoder.sv
// Lowest-set-bit index plus an any-bit flag over the per-core success vector.
// Purely combinational.
module pool_priority_encoder #(
    parameter int POOL_SIZE      = 2,
    parameter int POOL_SIZE_LOG2 = 1
) (
    input  logic [POOL_SIZE-1:0]      req_i,
    output logic [POOL_SIZE_LOG2-1:0] idx_o,
    output logic                      any_o
);

    // Scanning downwards lets the lowest set bit overwrite higher ones.
    always_comb begin
        idx_o = '0;
        any_o = |req_i;
        for (int i = POOL_SIZE - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = POOL_SIZE_LOG2'(i);
            end
        end
    end

endmodule

// File: rtl/pool_sequencer.sv
// Job-lifecycle sequencer for the hash-core pool: PLL-lock qualification,
// start pulsing, winner capture, READY and status LED drive.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_WAIT_LOCK | cores held in reset, counting stable synchronised lock
// ST_IDLE      | cores released, waiting for a job to be loaded
// ST_START     | one-cycle start pulse to all cores, winner cleared
// ST_RUN       | cores hashing; watching success / done flags
// ST_FOUND     | winner latched, result ready, LED solid on
// ST_EXHAUSTED | nonce range exhausted with no winner, result ready
module pool_sequencer
    import pool_pkg::*;
#(
    parameter int POOL_SIZE      = 2,
    parameter int POOL_SIZE_LOG2 = 1,
    parameter int LOCK_CYCLES    = DEF_LOCK_CYCLES,
    parameter int LED_DIV_LOG2   = DEF_LED_DIV_LOG2
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic                      pll_locked_in,
    input  logic                      job_loaded_in,
    input  logic                      readout_done_in,
    input  logic [POOL_SIZE-1:0]      cores_done_in,
    input  logic [POOL_SIZE-1:0]      cores_success_in,
    output logic                      cores_reset_out,
    output logic                      cores_start_out,
    output logic [POOL_SIZE_LOG2-1:0] winner_idx_out,
    output logic                      winner_valid_out,
    output logic                      ready_n_out,
    output logic                      status_led_n_out
);

    localparam int LOCK_CNT_W = $clog2(LOCK_CYCLES) + 1;
    localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_CYCLES - 1);

    logic                      lock_meta_q, lock_sync_q;
    logic [LED_DIV_LOG2:0]     led_cnt_q;
    pool_state_e               state_q, state_d;
    logic [LOCK_CNT_W-1:0]     lock_cnt_q, lock_cnt_d;
    logic [POOL_SIZE_LOG2-1:0] succ_idx;
    logic                      succ_any;

    pool_priority_encoder #(
        .POOL_SIZE      (POOL_SIZE),
        .POOL_SIZE_LOG2 (POOL_SIZE_LOG2)
    ) u_prio (
        .req_i (cores_success_in),
        .idx_o (succ_idx),
        .any_o (succ_any)
    );

    // pll_locked_in comes straight from the PLL, unrelated to clk_in.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            led_cnt_q   <= '0;
        end else begin
            lock_meta_q <= pll_locked_in;
            lock_sync_q <= lock_meta_q;
            led_cnt_q   <= led_cnt_q + (LED_DIV_LOG2 + 1)'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        if (state_q != ST_WAIT_LOCK && !lock_sync_q) begin
            state_d    = ST_WAIT_LOCK;
            lock_cnt_d = '0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (!lock_sync_q) begin
                        lock_cnt_d = '0;
                    end else if (lock_cnt_q == LOCK_LAST) begin
                        state_d    = ST_IDLE;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
                    end
                end
                ST_IDLE:  if (job_loaded_in) state_d = ST_START;
                ST_START: state_d = ST_RUN;
                // A newly loaded job aborts the running one before any result is taken.
                ST_RUN: begin
                    if (job_loaded_in)            state_d = ST_START;
                    else if (succ_any)            state_d = ST_FOUND;
                    else if (&cores_done_in)      state_d = ST_EXHAUSTED;
                end
                ST_FOUND, ST_EXHAUSTED: begin
                    if (job_loaded_in)            state_d = ST_START;
                    else if (readout_done_in)     state_d = ST_IDLE;
                end
                default: state_d = ST_WAIT_LOCK;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q          <= ST_WAIT_LOCK;
            lock_cnt_q       <= '0;
            cores_reset_out  <= 1'b1;
            cores_start_out  <= 1'b0;
            winner_idx_out   <= '0;
            winner_valid_out <= 1'b0;
            ready_n_out      <= 1'b1;
            status_led_n_out <= 1'b1;
        end else begin
            state_q         <= state_d;
            lock_cnt_q      <= lock_cnt_d;
            cores_reset_out <= (state_d == ST_WAIT_LOCK);
            cores_start_out <= (state_d == ST_START);
            ready_n_out     <= !(state_d == ST_FOUND || state_d == ST_EXHAUSTED);
            if (state_d == ST_START) begin
                winner_valid_out <= 1'b0;
            end else if (state_q == ST_RUN && state_d == ST_FOUND) begin
                winner_valid_out <= 1'b1;
                winner_idx_out   <= succ_idx;
            end
            if (state_d == ST_FOUND)    status_led_n_out <= 1'b0;
            else if (state_d == ST_RUN) status_led_n_out <= led_cnt_q[LED_DIV_LOG2];
            else                        status_led_n_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pool_sequencer.sv
// Self-checking bench for pool_sequencer: directed lock/job sequences, a
// vector table, and randomized traffic against a job-lifecycle model.
module tb_pool_sequencer;

    localparam int PS = 4;
    localparam int PL = 2;
    localparam int LC = 8;
    localparam int LD = 3;

    localparam int P_WAIT  = 0;
    localparam int P_IDLE  = 1;
    localparam int P_START = 2;
    localparam int P_RUN   = 3;
    localparam int P_FOUND = 4;
    localparam int P_EXH   = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pll = 1'b0;
    logic          job = 1'b0;
    logic          rdo = 1'b0;
    logic [PS-1:0] done = '0;
    logic [PS-1:0] succ = '0;
    logic          o_rst, o_start, o_valid, o_ready_n, o_led;
    logic [PL-1:0] o_idx;

    int n_vec = 0;
    int n_err = 0;

    // Model: two-deep lock pipeline, job phase, stable-lock run length, winner.
    bit m_s1, m_s2;
    int m_phase, m_run, m_idx;
    bit m_valid;

    typedef struct {
        logic          job, rdo;
        logic [PS-1:0] done, succ;
        logic          e_start;
        logic [PL-1:0] e_idx;
        logic          e_valid, e_ready_n, e_led, chk_led;
    } vec_t;

    vec_t tbl[$];

    pool_sequencer #(
        .POOL_SIZE      (PS),
        .POOL_SIZE_LOG2 (PL),
        .LOCK_CYCLES    (LC),
        .LED_DIV_LOG2   (LD)
    ) dut (
        .clk_in           (clk),
        .reset_in         (rst),
        .pll_locked_in    (pll),
        .job_loaded_in    (job),
        .readout_done_in  (rdo),
        .cores_done_in    (done),
        .cores_success_in (succ),
        .cores_reset_out  (o_rst),
        .cores_start_out  (o_start),
        .winner_idx_out   (o_idx),
        .winner_valid_out (o_valid),
        .ready_n_out      (o_ready_n),
        .status_led_n_out (o_led)
    );

    always #5 clk = ~clk;

    function automatic int lowest(input logic [PS-1:0] v);
        for (int i = 0; i < PS; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_phase = P_WAIT; m_run = 0; m_idx = 0; m_valid = 0;
    endtask

    task automatic goto_start();
        m_phase = P_START;
        m_valid = 0;
    endtask

    task automatic model_edge();
        bit lk;
        lk   = m_s2;
        m_s2 = m_s1;
        m_s1 = pll;
        if (m_phase != P_WAIT && !lk) begin
            m_phase = P_WAIT;
            m_run   = 0;
        end else if (m_phase == P_WAIT) begin
            m_run = lk ? m_run + 1 : 0;
            if (m_run == LC) begin
                m_phase = P_IDLE;
                m_run   = 0;
            end
        end else if (m_phase == P_IDLE) begin
            if (job) goto_start();
        end else if (m_phase == P_START) begin
            m_phase = P_RUN;
        end else if (m_phase == P_RUN) begin
            if (job) goto_start();
            else if (succ != 0) begin
                m_idx = lowest(succ); m_valid = 1; m_phase = P_FOUND;
            end else if (done == '1) m_phase = P_EXH;
        end else begin
            if (job) goto_start();
            else if (rdo) m_phase = P_IDLE;
        end
    endtask

    task automatic check_model();
        chk("cores_reset", o_rst, 8'(m_phase == P_WAIT));
        chk("cores_start", o_start, 8'(m_phase == P_START));
        chk("ready_n", o_ready_n, 8'(!(m_phase == P_FOUND || m_phase == P_EXH)));
        chk("winner_valid", o_valid, 8'(m_valid));
        chk("winner_idx", o_idx, 8'(m_idx));
        if (m_phase != P_RUN) chk("status_led_n", o_led, 8'(m_phase != P_FOUND));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_model();
    endtask

    task automatic add(input logic j, input logic r, input logic [3:0] d, input logic [3:0] s,
                       input logic es, input logic [1:0] ei, input logic ev,
                       input logic er, input logic el, input logic cl);
        vec_t v;
        v.job = j; v.rdo = r; v.done = d; v.succ = s;
        v.e_start = es; v.e_idx = ei; v.e_valid = ev; v.e_ready_n = er;
        v.e_led = el; v.chk_led = cl;
        tbl.push_back(v);
    endtask

    initial begin
        //   job rdo done   succ    start idx valid rdy  led  chkled
        add(1, 0, 4'h0, 4'h0,   1, 0, 0, 1, 1, 1); // IDLE -> START
        add(0, 0, 4'h0, 4'h0,   0, 0, 0, 1, 1, 0); // RUN
        add(0, 0, 4'h0, 4'b0100, 0, 2, 1, 0, 0, 1); // success core 2
        add(0, 0, 4'h0, 4'h0,   0, 2, 1, 0, 0, 1);
        add(0, 0, 4'hF, 4'hF,   0, 2, 1, 0, 0, 1); // flags ignored in FOUND
        add(0, 1, 4'h0, 4'h0,   0, 2, 1, 1, 1, 1); // readout -> IDLE, winner held
        add(1, 0, 4'h0, 4'h0,   1, 2, 0, 1, 1, 1);
        add(0, 0, 4'h0, 4'h0,   0, 2, 0, 1, 1, 0);
        add(0, 0, 4'hF, 4'b1010, 0, 1, 1, 0, 0, 1); // collision: FOUND wins
        add(1, 0, 4'h0, 4'h0,   1, 1, 0, 1, 1, 1); // new job preempts readout
        add(0, 0, 4'h0, 4'h0,   0, 1, 0, 1, 1, 0);
        add(0, 0, 4'h3, 4'h0,   0, 1, 0, 1, 1, 0);
        add(0, 0, 4'h7, 4'h0,   0, 1, 0, 1, 1, 0);
        add(0, 0, 4'hF, 4'h0,   0, 1, 0, 0, 1, 1); // exhausted
        add(0, 1, 4'h0, 4'h0,   0, 1, 0, 1, 1, 1);
        add(1, 0, 4'h0, 4'h0,   1, 1, 0, 1, 1, 1);
        add(0, 0, 4'h0, 4'b0001, 0, 1, 0, 1, 1, 0); // success during START ignored
        add(1, 0, 4'h0, 4'h0,   1, 1, 0, 1, 1, 1); // abort mid-RUN
        add(0, 0, 4'h0, 4'b1000, 0, 1, 0, 1, 1, 0); // old-job success ignored
        add(0, 0, 4'h0, 4'h0,   0, 1, 0, 1, 1, 0);
        add(0, 0, 4'h0, 4'b1000, 0, 3, 1, 0, 0, 1);

        model_reset();
        #8;
        chk("rst_cores_reset", o_rst, 1);
        chk("rst_cores_start", o_start, 0);
        chk("rst_winner_idx", o_idx, 0);
        chk("rst_winner_valid", o_valid, 0);
        chk("rst_ready_n", o_ready_n, 1);
        chk("rst_led", o_led, 1);
        #4;
        rst = 1'b0;
        pll = 1'b1;

        // Lock with a one-cycle drop reaching the counter at count 5.
        for (int k = 1; k <= 5; k++) step();
        pll = 1'b0;
        step();
        pll = 1'b1;
        for (int k = 7; k <= 16; k++) begin
            step();
            chk("lock_restart", o_rst, 8'(k < 16));
        end

        foreach (tbl[i]) begin
            job = tbl[i].job; rdo = tbl[i].rdo; done = tbl[i].done; succ = tbl[i].succ;
            step();
            chk("tbl_start", o_start, 8'(tbl[i].e_start));
            chk("tbl_idx", o_idx, 8'(tbl[i].e_idx));
            chk("tbl_valid", o_valid, 8'(tbl[i].e_valid));
            chk("tbl_ready_n", o_ready_n, 8'(tbl[i].e_ready_n));
            if (tbl[i].chk_led) chk("tbl_led", o_led, 8'(tbl[i].e_led));
            job = 0; rdo = 0; done = '0; succ = '0;
        end

        // Lock loss while FOUND.
        pll = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("lockloss_cores_reset", o_rst, 1);
        chk("lockloss_ready_n", o_ready_n, 1);
        chk("lockloss_idx_held", o_idx, 3);
        chk("lockloss_valid_held", o_valid, 1);
        pll = 1'b1;
        for (int k = 0; k < 12; k++) step();

        for (int k = 0; k < 3000; k++) begin
            pll  = ($urandom_range(0, 99) != 0);
            job  = ($urandom_range(0, 15) == 0);
            rdo  = ($urandom_range(0, 7) == 0);
            done = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            succ = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
            step();
        end

        // Bring to IDLE within a bounded window, then async reset mid-RUN.
        pll = 1'b1; job = 0; rdo = 1; done = '0; succ = '0;
        for (int k = 0; k < 40 && m_phase != P_IDLE; k++) step();
        chk("reach_idle_ready_n", o_ready_n, 1);
        chk("reach_idle_cores_reset", o_rst, 0);
        rdo = 0;
        job = 1; step(); job = 0;
        step();
        succ = 4'b0100; step(); succ = '0;
        job = 1; step(); job = 0;
        step();
        chk("pre_reset_idx", o_idx, 2);
        chk("pre_reset_cores_reset", o_rst, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_cores_reset", o_rst, 1);
        chk("async_cores_start", o_start, 0);
        chk("async_winner_idx", o_idx, 0);
        chk("async_winner_valid", o_valid, 0);
        chk("async_ready_n", o_ready_n, 1);
        chk("async_led", o_led, 1);
        model_reset();
        #3;
        rst = 1'b0;
        for (int k = 0; k < 14; k++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
